// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for Pong: serve countdown, live play, post-point pause,
// game over, with per-player BCD scores and serve direction selection.
module pong_match_sequencer #(
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 30,
  parameter int WIN_SCORE   = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       serve_right,
  output logic [3:0] score_one_tens,
  output logic [3:0] score_one_ones,
  output logic [3:0] score_two_tens,
  output logic [3:0] score_two_ones,
  output logic [2:0] state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [6:0] SERVE_LOAD = 7'(SERVE_TICKS);
  localparam logic [6:0] POINT_LOAD = 7'(POINT_TICKS);
  localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [6:0] timer_q, timer_d;
  logic [6:0] bin_one_q, bin_one_d, bin_two_q, bin_two_d;
  logic [7:0] bcd_one_q, bcd_one_d, bcd_two_q, bcd_two_d;
  logic       serve_d, ball_reset_d, ball_enable_d;
  logic [1:0] winner_d;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    if (bcd == 8'h99) return bcd;
    if (bcd[3:0] == 4'd9) return {bcd[7:4] + 4'd1, 4'd0};
    return {bcd[7:4], bcd[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bin_inc(input logic [6:0] bin);
    return (bin == 7'd99) ? bin : bin + 7'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bin_one_d = bin_one_q;
    bin_two_d = bin_two_q;
    bcd_one_d = bcd_one_q;
    bcd_two_d = bcd_two_q;
    serve_d   = serve_right;
    winner_d  = winner;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = SERVE;
          timer_d   = SERVE_LOAD;
          bin_one_d = '0;
          bin_two_d = '0;
          bcd_one_d = '0;
          bcd_two_d = '0;
          serve_d   = 1'b1;
          winner_d  = 2'b00;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (timer_q <= 7'd1) begin
            state_d = PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      PLAY: begin
        // Player one takes priority when both pulses land together.
        if (p1_point) begin
          bin_one_d = bin_inc(bin_one_q);
          bcd_one_d = bcd_inc(bcd_one_q);
          serve_d   = 1'b0;
          if (bin_inc(bin_one_q) == WIN_BIN) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d = POINT;
            timer_d = POINT_LOAD;
          end
        end else if (p2_point) begin
          bin_two_d = bin_inc(bin_two_q);
          bcd_two_d = bcd_inc(bcd_two_q);
          serve_d   = 1'b1;
          if (bin_inc(bin_two_q) == WIN_BIN) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            state_d = POINT;
            timer_d = POINT_LOAD;
          end
        end
      end
      POINT: begin
        if (frame_tick) begin
          if (timer_q <= 7'd1) begin
            state_d = SERVE;
            timer_d = SERVE_LOAD;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ball_reset_d  = (state_d != PLAY);
    ball_enable_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bin_one_q   <= '0;
      bin_two_q   <= '0;
      bcd_one_q   <= '0;
      bcd_two_q   <= '0;
      serve_right <= 1'b1;
      winner      <= 2'b00;
      ball_reset  <= 1'b1;
      ball_enable <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bin_one_q   <= bin_one_d;
      bin_two_q   <= bin_two_d;
      bcd_one_q   <= bcd_one_d;
      bcd_two_q   <= bcd_two_d;
      serve_right <= serve_d;
      winner      <= winner_d;
      ball_reset  <= ball_reset_d;
      ball_enable <= ball_enable_d;
    end
  end

  assign state          = state_q;
  assign score_one_tens = bcd_one_q[7:4];
  assign score_one_ones = bcd_one_q[3:0];
  assign score_two_tens = bcd_two_q[7:4];
  assign score_two_ones = bcd_two_q[3:0];

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: directed match walk-through pinned by literal
// expectations, then random play checked every cycle against an integer score model.
module tb_pong_match_sequencer;

  localparam int ST = 3;
  localparam int PT = 2;
  localparam int WS = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       ball_reset, ball_enable, serve_right;
  logic [3:0] score_one_tens, score_one_ones, score_two_tens, score_two_ones;
  logic [2:0] state;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  int m_state, m_p1, m_p2, m_timer, m_winner;
  bit m_serve;
  bit model_valid = 1'b0;

  pong_match_sequencer #(
    .SERVE_TICKS(ST),
    .POINT_TICKS(PT),
    .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .frame_tick(frame_tick),
    .p1_point(p1_point),
    .p2_point(p2_point),
    .ball_reset(ball_reset),
    .ball_enable(ball_enable),
    .serve_right(serve_right),
    .score_one_tens(score_one_tens),
    .score_one_ones(score_one_ones),
    .score_two_tens(score_two_tens),
    .score_two_ones(score_two_ones),
    .state(state),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit s, input bit ft, input bit a, input bit b);
    @(negedge clk);
    reset = rst_n;
    start = s;
    frame_tick = ft;
    p1_point = a;
    p2_point = b;
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 1, 0, 0);
  endtask

  function automatic int sat99(input int s);
    return (s > 99) ? 99 : s;
  endfunction

  function automatic void start_match();
    m_state = 1; m_p1 = 0; m_p2 = 0; m_timer = ST; m_serve = 1; m_winner = 0;
  endfunction

  // Reference: match phase as an integer, scores as plain integers, countdown as
  // the number of frame ticks still to wait in the current phase.
  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_p1 = 0; m_p2 = 0; m_timer = 0; m_serve = 1; m_winner = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_state == 0 || m_state == 4) begin
        if (start) start_match();
      end else if (m_state == 1 || m_state == 3) begin
        if (frame_tick) begin
          m_timer--;
          if (m_timer == 0) begin
            if (m_state == 1) m_state = 2;
            else begin m_state = 1; m_timer = ST; end
          end
        end
      end else if (m_state == 2 && (p1_point || p2_point)) begin
        if (p1_point) begin m_p1 = sat99(m_p1 + 1); m_serve = 0; end
        else begin m_p2 = sat99(m_p2 + 1); m_serve = 1; end
        if (m_p1 == WS && p1_point) begin m_state = 4; m_winner = 1; end
        else if (m_p2 == WS && !p1_point) begin m_state = 4; m_winner = 2; end
        else begin m_state = 3; m_timer = PT; end
      end
    end
    #1;
    if (model_valid) begin
      checkOutput("model_state", state, m_state);
      checkOutput("model_scores", {score_one_tens, score_one_ones, score_two_tens, score_two_ones},
                  {4'(m_p1 / 10), 4'(m_p1 % 10), 4'(m_p2 / 10), 4'(m_p2 % 10)});
      checkOutput("model_ball", {ball_reset, ball_enable}, (m_state == 2) ? 2'b01 : 2'b10);
      checkOutput("model_serve", serve_right, m_serve);
      checkOutput("model_winner", winner, m_winner);
    end
  end

  initial begin
    repeat (3) applyStimulus(0, 1, 0, 1, 0);
    checkOutput("reset_state", state, 3'd0);
    checkOutput("reset_scores", {score_one_tens, score_one_ones, score_two_tens, score_two_ones}, 16'h0000);
    checkOutput("reset_ball", {ball_reset, ball_enable}, 2'b10);
    checkOutput("reset_serve", serve_right, 1'b1);
    checkOutput("reset_winner", winner, 2'b00);

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start_serve", state, 3'd1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) applyStimulus(1, 0, 0, 0, 0);
      if (k == 3) begin
        checkOutput("serve_before_expiry", state, 3'd1);
        checkOutput("serve_enable_low", ball_enable, 1'b0);
      end
      applyStimulus(1, 0, 1, 0, 0);
    end
    checkOutput("serve_to_play", state, 3'd2);
    checkOutput("serve_enable_high", ball_enable, 1'b1);

    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("p1_point_state", state, 3'd3);
    checkOutput("p1_point_score", {score_one_tens, score_one_ones}, 8'h01);
    checkOutput("p1_point_serve", serve_right, 1'b0);
    ticks(PT);
    checkOutput("point_to_serve", state, 3'd1);
    ticks(ST);
    checkOutput("serve_to_play_2", state, 3'd2);

    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("simul_scores", {score_one_tens, score_one_ones, score_two_tens, score_two_ones}, 16'h0200);
    checkOutput("simul_serve", serve_right, 1'b0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("point_ignores_p2", {score_two_tens, score_two_ones}, 8'h00);
    ticks(PT);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("serve_ignores_p2", {score_two_tens, score_two_ones}, 8'h00);
    ticks(ST);
    checkOutput("back_in_play", state, 3'd2);

    for (int i = 1; i <= WS; i++) begin
      applyStimulus(1, 0, 0, 0, 1);
      if (i == 10) begin
        checkOutput("p2_ten_bcd", {score_two_tens, score_two_ones}, 8'h10);
        checkOutput("p2_ten_state", state, 3'd3);
      end
      if (i < WS) ticks(PT + ST);
    end
    checkOutput("win_state", state, 3'd4);
    checkOutput("win_winner", winner, 2'b10);
    checkOutput("win_score", {score_two_tens, score_two_ones}, 8'h11);

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("restart_state", state, 3'd1);
    checkOutput("restart_scores", {score_one_tens, score_one_ones, score_two_tens, score_two_ones}, 16'h0000);
    checkOutput("restart_winner", winner, 2'b00);
    applyStimulus(1, 0, 0, 0, 0);
    ticks(ST);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 0);
      ticks(PT + ST);
    end
    checkOutput("mid_play_score", {state, score_one_ones}, {3'd2, 4'd3});
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_play_reset", {state, score_one_ones}, {3'd0, 4'd0});

    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(99) != 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                    $urandom_range(5) == 0, $urandom_range(5) == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
